hamming_secded_enc: RTL

Parametrised SECDED (single-error-correct, double-error-detect) Hamming encoder with valid/ready flow control, an optional extra pipeline stage, an error-injection path for decoder testing and an encoded-word counter. It is the next generation of the fixed 64-bit combinational encoder. It sits between the data producer and the link/memory write path and accepts one word per cycle at full throughput.

---
 rtl/hamming_secded_enc.sv | 115 +++++++++++
 1 files changed

// File: rtl/hamming_secded_enc.sv
// Parametrised SECDED Hamming encoder with valid/ready flow control, optional
// extra pipeline stage, codeword error injection and an accepted-word counter.
module hamming_secded_enc #(
    parameter  int DATA_W = 64,
    parameter  int PIPE   = 0,
    parameter  int CNT_W  = 32,
    // Smallest p with 2^p >= DATA_W + p + 1 over the legal range 4..247.
    localparam int P      = (DATA_W <= 4)   ? 3 :
                            (DATA_W <= 11)  ? 4 :
                            (DATA_W <= 26)  ? 5 :
                            (DATA_W <= 57)  ? 6 :
                            (DATA_W <= 120) ? 7 : 8,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] inj_mask,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  enc_count
);

    function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [DATA_W-1:0] rem;
        // NOTE: function locals are scratch variables, so blocking assignments
        // are correct here; registered state below uses non-blocking only.
        c   = '0;
        rem = d;
        for (int j = 1; j < CODE_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                c[j] = rem[0];
                rem  = rem >> 1;
            end
        end
        for (int i = 0; i < P; i++) begin
            for (int j = 1; j < CODE_W; j++) begin
                if (((j >> i) & 1) == 1 && j != (1 << i)) begin
                    c[1 << i] = c[1 << i] ^ c[j];
                end
            end
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    logic [CODE_W-1:0] w_enc;
    logic              w_stage_ready;
    logic              w_accept;
    logic [CODE_W-1:0] r_out_code;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_count;

    assign w_enc     = f_encode(in_data) ^ inj_mask;
    assign in_ready  = !reset && w_stage_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_code  = r_out_code;
    assign out_valid = r_out_valid;
    assign enc_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    if (PIPE == 0) begin : g_pipe0
        assign w_stage_ready = !r_out_valid || out_ready;

        always_ff @(posedge clk) begin
            // NOTE: code registers are reset too, because out_code must read 0
            // during and right after reset, not just be qualified by out_valid.
            if (reset) begin
                r_out_valid <= 1'b0;
                r_out_code  <= '0;
            end else if (w_stage_ready) begin
                r_out_valid <= in_valid;
                if (in_valid) r_out_code <= w_enc;
            end
        end
    end else begin : g_pipe1
        logic              r_s1_valid;
        logic [CODE_W-1:0] r_s1_code;
        logic              w_s2_load;

        // S1 may load whenever it is empty or drains into S2 this cycle.
        assign w_s2_load     = !r_out_valid || out_ready;
        assign w_stage_ready = !r_s1_valid || w_s2_load;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1_valid  <= 1'b0;
                r_s1_code   <= '0;
                r_out_valid <= 1'b0;
                r_out_code  <= '0;
            end else begin
                if (w_s2_load) begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) r_out_code <= r_s1_code;
                end
                if (w_stage_ready) begin
                    r_s1_valid <= in_valid;
                    if (in_valid) r_s1_code <= w_enc;
                end
            end
        end
    end

endmodule
